// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC command link (transmitter and receiver).
// Frame geometry, default frame patterns and the frame type encoding.
package ttc_pkg;

  localparam int FRAME_BITS = 16;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

  localparam logic [FRAME_BITS-1:0] DEFAULT_SYNC_WORD = 16'h817E;
  localparam logic [FRAME_BITS-1:0] DEFAULT_NOOP_WORD = 16'h6969;

  typedef enum logic [1:0] {
    FT_NOOP = 2'd0,
    FT_SYNC = 2'd1,
    FT_DATA = 2'd2
  } frame_type_e;

endpackage

// File: rtl/ttc_tx_piso.sv
// Frame serialiser: loads one 16-bit word every 16 cycles and shifts it out MSB first.
// The load strobe is exported so the parent can pick the word for the next frame.
module ttc_tx_piso
  import ttc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] load_word,
  output logic                  load,
  output logic                  dataout,
  output logic                  frame_start
);

  logic [FRAME_BITS-1:0] shift_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  // Reset parks the counter on the last bit so the first edge out of reset loads a frame.
  assign load    = (bit_cnt == BIT_CNT_LAST);
  assign dataout = shift_reg[FRAME_BITS-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt     <= BIT_CNT_LAST;
      frame_start <= 1'b0;
    end else if (load) begin
      shift_reg   <= load_word;
      bit_cnt     <= '0;
      frame_start <= 1'b1;
    end else begin
      shift_reg   <= {shift_reg[FRAME_BITS-2:0], 1'b0};
      bit_cnt     <= bit_cnt + 1'b1;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: rtl/ttc_tx.sv
// TTC command link transmitter: single-entry hold register, frame selection
// (SYNC / DATA / NOOP), periodic sync insertion and a launched-data counter.
module ttc_tx
  import ttc_pkg::*;
#(
  parameter int unsigned           SYNC_INTERVAL = 32,
  parameter logic [FRAME_BITS-1:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
  parameter logic [FRAME_BITS-1:0] NOOP_WORD     = DEFAULT_NOOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic                  dataout,
  output logic                  frame_start,
  output logic [1:0]            frame_type,
  output logic [15:0]           data_sent_cnt
);

  localparam int SYNC_W = $clog2(SYNC_INTERVAL);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_INTERVAL - 1);

  logic [FRAME_BITS-1:0] hold_word;
  logic                  hold_valid;
  logic                  hold_valid_nx;
  logic [SYNC_W-1:0]     sync_cnt;
  frame_type_e           frame_type_q;
  frame_type_e           sel_type;
  logic [FRAME_BITS-1:0] load_word;
  logic                  load;
  logic                  sync_due;
  logic                  xfer;
  logic                  consume;

  ttc_tx_piso u_piso (
    .clk         (clk),
    .rst         (rst),
    .load_word   (load_word),
    .load        (load),
    .dataout     (dataout),
    .frame_start (frame_start)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    load_word     = NOOP_WORD;
    sel_type      = FT_NOOP;
    sync_due      = (sync_cnt == SYNC_LAST);
    xfer          = data_in_valid && data_in_ready;
    consume       = load && !sync_due && hold_valid;
    hold_valid_nx = hold_valid;
    if (sync_due) begin
      load_word = SYNC_WORD;
      sel_type  = FT_SYNC;
    end else if (hold_valid) begin
      load_word = hold_word;
      sel_type  = FT_DATA;
    end
    // Ready is only high while the hold is empty, so consume and xfer never coincide.
    if (consume) hold_valid_nx = 1'b0;
    if (xfer)    hold_valid_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_word     <= '0;
      hold_valid    <= 1'b0;
      data_in_ready <= 1'b0;
      sync_cnt      <= SYNC_LAST;
      frame_type_q  <= FT_NOOP;
      data_sent_cnt <= '0;
    end else begin
      hold_valid    <= hold_valid_nx;
      // Registered from the next hold state so a full hold never sees ready high.
      data_in_ready <= !hold_valid_nx;
      if (xfer) hold_word <= data_in;
      if (load) begin
        frame_type_q <= sel_type;
        sync_cnt     <= sync_due ? '0 : sync_cnt + 1'b1;
        if (consume) data_sent_cnt <= data_sent_cnt + 16'd1;
      end
    end
  end

  assign frame_type = frame_type_q;

endmodule

// File: doc/ttc_tx.md
Name: ttc_tx

Overview:
- Transmit end of the TTC command link: the encoder that generates the 160 Mb/s serial stream the emulator's TTC receiver decodes.
- Accepts 16-bit command words over a valid/ready handshake and serialises them MSB-first, one bit per clk cycle, in 16-bit frames.
- Fills idle frame slots with NOOP and forces a SYNC frame at a fixed frame interval so the receiver's word alignment stays locked.
- Used in the DAQ-side test firmware and in the emulator loopback bench, driving the LVDS output buffer.

Parameters:
- SYNC_INTERVAL, 32, frames per sync period; one SYNC frame plus SYNC_INTERVAL-1 other frames; legal range 2..256.
- SYNC_WORD, 16'h817E, sync frame pattern.
- NOOP_WORD, 16'h6969, idle frame pattern.

Ports:
- clk  input  1  160 MHz bit clock; one serial bit per cycle.
- rst  input  1  synchronous, active-high reset.
- data_in  input  16  command word to transmit.
- data_in_valid  input  1  data_in is valid.
- data_in_ready  output  1  block can accept a word this cycle; a transfer occurs when valid and ready are both high.
- dataout  output  1  serial TTC stream, MSB of each frame first, registered.
- frame_start  output  1  one-cycle pulse, coincident with the first (MSB) bit of each frame on dataout.
- frame_type  output  2  0=NOOP, 1=SYNC, 2=DATA; valid while frame_start is high, holds its value otherwise.
- data_sent_cnt  output  16  count of DATA frames launched; wraps.

Behaviour:
- Reset values: dataout=0, frame_start=0, frame_type=0, data_in_ready=0, data_sent_cnt=0.
- Internal reset values: shift_reg=0, bit_cnt=15, sync_cnt=SYNC_INTERVAL-1 (sync due), hold_valid=0.
- Rst held high: all outputs stay at reset values.
- Reset mid-frame: the frame is truncated and the hold word is discarded. The first edge after rst falls is a load edge, and that first frame is SYNC.
- Load edge: the edge where bit_cnt==15. At that edge, bit_cnt<=0 and shift_reg loads the selected word:
  - sync_cnt==SYNC_INTERVAL-1: load SYNC_WORD, sync_cnt<=0, frame_type<=1. The hold word, if any, is not consumed.
  - else if hold_valid: load the hold word, hold_valid<=0, data_sent_cnt+1, sync_cnt+1, frame_type<=2.
  - else: load NOOP_WORD, sync_cnt+1, frame_type<=0.
- Other edges: shift_reg shifts left by one with 0 fill; bit_cnt+1.
- dataout = shift_reg[15] (flop output). The MSB appears in the cycle after the load edge, together with frame_start=1.
- Frame period is exactly 16 cycles. No gaps between frames and no partial frames except on reset.
- Hold register (single entry):
  - data_in_ready = !hold_valid && !rst, registered.
  - On transfer: hold <= data_in, hold_valid<=1.
  - There is no bypass. A word transferred on the load edge itself is not sent in that frame; that frame is NOOP (or SYNC) and the word goes out in the next frame.
- Sustained throughput is one word per frame. Ready deasserts for at least 1 cycle per frame when streaming.
- Data words equal to SYNC_WORD or NOOP_WORD are transmitted verbatim with frame_type=2; legality is the sender's responsibility.
- data_sent_cnt wraps 16'hFFFF -> 0.

Decomposition:
- Package ttc_pkg holds:
  - FRAME_BITS=16
  - default SYNC_WORD and NOOP_WORD
  - frame_type encodings FT_NOOP, FT_SYNC, FT_DATA
- The TTC receiver shares this package.
- One sub-module, ttc_tx_piso: a 16-bit load/shift register with bit counter, load-edge strobe, dataout and frame_start.
- Frame selection, hold register, sync counter and stats stay in ttc_tx.

Test Plan:
- Release rst with no input, capture 33 frames -> frame 0 = 817E starting 1 cycle after the first post-reset edge; frames 1-31 = 6969 with frame_type=0; frame 32 = 817E with frame_type=1; frame_start every 16 cycles.
- Single word A5C3 with valid at cycle 5 after reset -> ready=1 and transfer at cycle 5; frame 1 = A5C3 with frame_type=2; data_sent_cnt=1; frames 2+ NOOP.
- Stream 40 words 0x0001..0x0028 with valid held high -> one transfer per frame; frames 1-31 carry words 1-31; frame 32 = SYNC; words 32-40 in frames 33-41 in order; no loss or duplication; data_sent_cnt=40.
- Word offered exactly on a load edge with hold empty -> captured, current frame NOOP, word sent next frame.
- Word held in hold when SYNC is due -> SYNC sent, ready stays 0, word sent in the following frame.
- rst pulsed for 1 cycle at bit 7 of a data frame with hold full -> outputs at reset values next cycle; held word never transmitted; next frame is 817E.
- Preload data_sent_cnt to FFFF via 65535 words (or a force in the bench), send 1 more -> count = 0000.
